frame_buffer_scheduler: RTL and testbench

Triple-buffer scheduler for the DDR frame store between the camera write path (capture plus AXI writer) and the HDMI read path. It owns three frame buffers in DDR. It hands the writer a free buffer base address each frame and hands the reader the newest completed frame. Frames are dropped, never torn, when producer and consumer rates differ. Single clock domain; reader-side events arrive already synchronised into p_clock.

---
 rtl/frame_buffer_scheduler_if.sv | 35 +++
 rtl/frame_buffer_scheduler.sv | 220 ++++++++++++++++++++++
 tb/tb_frame_buffer_scheduler.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/frame_buffer_scheduler_if.sv
// Bundle between the frame buffer scheduler and its neighbours. The capture/AXI
// writer and HDMI reader event levels flow in. Buffer selections and statistics
// flow out.
interface frame_buffer_scheduler_if #(
    parameter int CNT_W = 16
);
    logic             enable;
    logic             wr_frame_start;
    logic             wr_frame_end;
    logic             rd_frame_start;
    logic [31:0]      wr_base_addr;
    logic [1:0]       wr_buf_idx;
    logic             wr_active;
    logic [31:0]      rd_base_addr;
    logic [1:0]       rd_buf_idx;
    logic             rd_valid;
    logic [CNT_W-1:0] frames_written;
    logic [CNT_W-1:0] frames_dropped;

    // Side that drives the events and consumes the buffer selections.
    modport master (
        output enable, wr_frame_start, wr_frame_end, rd_frame_start,
        input  wr_base_addr, wr_buf_idx, wr_active,
        input  rd_base_addr, rd_buf_idx, rd_valid,
        input  frames_written, frames_dropped
    );

    // Scheduler side.
    modport slave (
        input  enable, wr_frame_start, wr_frame_end, rd_frame_start,
        output wr_base_addr, wr_buf_idx, wr_active,
        output rd_base_addr, rd_buf_idx, rd_valid,
        output frames_written, frames_dropped
    );
endinterface

// File: rtl/frame_buffer_scheduler.sv
// Triple-buffer scheduler for the DDR frame store.
// Three buffers rotate between the roles W (being written), P (completed,
// waiting for the reader) and R (being displayed). A finished write swaps W
// and P. A reader vsync takes P only when it holds an unread frame, so frames
// are dropped but never torn. All outputs come straight from registers.
module frame_buffer_scheduler #(
    parameter logic [31:0] BASE_ADDR    = 32'h1000_0000,
    parameter logic [31:0] FRAME_STRIDE = 32'h0004_0000,
    parameter int          CNT_W        = 16
) (
    input  logic                      p_clock,
    input  logic                      rst,
    frame_buffer_scheduler_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_SOF = 2'd1,
        ST_WRITING  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Base address of a buffer index. Index 3 never occurs because the roles
    // are always a permutation of 0..2.
    function automatic logic [31:0] addr_of(input logic [1:0] idx);
        logic [31:0] a;
        case (idx)
            2'd0:    a = BASE_ADDR;
            2'd1:    a = BASE_ADDR + FRAME_STRIDE;
            2'd2:    a = BASE_ADDR + (FRAME_STRIDE << 1);
            default: a = BASE_ADDR;
        endcase
        return a;
    endfunction

    state_t           r_state;
    state_t           w_state_nxt;

    logic             r_start_q;
    logic             r_end_q;
    logic             r_rd_q;
    logic             w_ev_start;
    logic             w_ev_end;
    logic             w_ev_rd;

    logic [1:0]       r_w;
    logic [1:0]       r_p;
    logic [1:0]       r_r;
    logic             r_pend_valid;
    logic             r_rd_valid;
    logic             r_wr_active;
    logic [31:0]      r_wr_addr;
    logic [31:0]      r_rd_addr;
    logic [CNT_W-1:0] r_written;
    logic [CNT_W-1:0] r_dropped;

    // Roles after the writer side is applied, before the reader side.
    logic [1:0]       w_w_mid;
    logic [1:0]       w_p_mid;
    logic             w_pend_mid;
    logic             w_drop_inc;
    logic             w_written_inc;

    logic [1:0]       w_r_nxt;
    logic [1:0]       w_p_nxt;
    logic             w_pend_nxt;
    logic             w_rd_valid_nxt;
    logic [CNT_W-1:0] w_written_nxt;
    logic [CNT_W-1:0] w_dropped_nxt;

    // A level held high produces one event, on its first cycle.
    assign w_ev_start = bus.wr_frame_start & ~r_start_q;
    assign w_ev_end   = bus.wr_frame_end   & ~r_end_q;
    assign w_ev_rd    = bus.rd_frame_start & ~r_rd_q;

    // Write FSM next state plus the writer-side role swap. An end is handled
    // before a start in the same cycle, so a back-to-back frame starts on the
    // freshly swapped W.
    always_comb begin
        w_state_nxt   = r_state;
        w_w_mid       = r_w;
        w_p_mid       = r_p;
        w_pend_mid    = r_pend_valid;
        w_drop_inc    = 1'b0;
        w_written_inc = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.enable) begin
                    w_state_nxt = ST_WAIT_SOF;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WAIT_SOF: begin
                if (!bus.enable) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_ev_start) begin
                    w_state_nxt = ST_WRITING;
                end else begin
                    w_state_nxt = ST_WAIT_SOF;
                end
            end
            ST_WRITING: begin
                if (w_ev_end) begin
                    w_w_mid       = r_p;
                    w_p_mid       = r_w;
                    w_pend_mid    = 1'b1;
                    w_written_inc = 1'b1;
                    // An unread pending frame is being overwritten.
                    w_drop_inc    = r_pend_valid;
                    if (w_ev_start) begin
                        w_state_nxt = ST_WRITING;
                    end else if (bus.enable) begin
                        w_state_nxt = ST_WAIT_SOF;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else if (w_ev_start) begin
                    // Aborted frame: restart in the same buffer.
                    w_drop_inc  = 1'b1;
                    w_state_nxt = ST_WRITING;
                end else begin
                    // Dropping enable does not abort; wait for the end.
                    w_state_nxt = ST_WRITING;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Reader side. It acts on the roles the writer side just produced.
    always_comb begin
        w_r_nxt        = r_r;
        w_p_nxt        = w_p_mid;
        w_pend_nxt     = w_pend_mid;
        w_rd_valid_nxt = r_rd_valid;
        if (w_ev_rd && w_pend_mid) begin
            w_r_nxt        = w_p_mid;
            w_p_nxt        = r_r;
            w_pend_nxt     = 1'b0;
            w_rd_valid_nxt = 1'b1;
        end else begin
            // The reader repeats the frame it already holds.
            w_r_nxt        = r_r;
            w_p_nxt        = w_p_mid;
        end
    end

    // Statistics: written wraps, dropped saturates.
    always_comb begin
        w_written_nxt = r_written;
        w_dropped_nxt = r_dropped;
        if (w_written_inc) begin
            w_written_nxt = r_written + CNT_ONE;
        end else begin
            w_written_nxt = r_written;
        end
        if (w_drop_inc && (r_dropped != CNT_MAX)) begin
            w_dropped_nxt = r_dropped + CNT_ONE;
        end else begin
            w_dropped_nxt = r_dropped;
        end
    end

    // Write FSM state register.
    always_ff @(posedge p_clock) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Edge detectors, roles, registered outputs and counters.
    always_ff @(posedge p_clock) begin
        if (rst) begin
            r_start_q    <= 1'b0;
            r_end_q      <= 1'b0;
            r_rd_q       <= 1'b0;
            r_w          <= 2'd0;
            r_p          <= 2'd1;
            r_r          <= 2'd2;
            r_pend_valid <= 1'b0;
            r_rd_valid   <= 1'b0;
            r_wr_active  <= 1'b0;
            r_wr_addr    <= BASE_ADDR;
            r_rd_addr    <= BASE_ADDR + (FRAME_STRIDE << 1);
            r_written    <= {CNT_W{1'b0}};
            r_dropped    <= {CNT_W{1'b0}};
        end else begin
            r_start_q    <= bus.wr_frame_start;
            r_end_q      <= bus.wr_frame_end;
            r_rd_q       <= bus.rd_frame_start;
            r_w          <= w_w_mid;
            r_p          <= w_p_nxt;
            r_r          <= w_r_nxt;
            r_pend_valid <= w_pend_nxt;
            r_rd_valid   <= w_rd_valid_nxt;
            r_wr_active  <= (w_state_nxt == ST_WRITING);
            r_wr_addr    <= addr_of(w_w_mid);
            r_rd_addr    <= addr_of(w_r_nxt);
            r_written    <= w_written_nxt;
            r_dropped    <= w_dropped_nxt;
        end
    end

    assign bus.wr_base_addr   = r_wr_addr;
    assign bus.wr_buf_idx     = r_w;
    assign bus.wr_active      = r_wr_active;
    assign bus.rd_base_addr   = r_rd_addr;
    assign bus.rd_buf_idx     = r_r;
    assign bus.rd_valid       = r_rd_valid;
    assign bus.frames_written = r_written;
    assign bus.frames_dropped = r_dropped;

endmodule

// File: tb/tb_frame_buffer_scheduler.sv
// Bench for frame_buffer_scheduler: directed scenarios with hand-computed
// checkpoints, then randomized event levels. A behavioural model tracks which
// buffer holds which role and is compared with the DUT on every cycle.
module tb_frame_buffer_scheduler;

    logic p_clock = 1'b0;
    logic rst     = 1'b1;

    frame_buffer_scheduler_if #(.CNT_W(16)) bus();

    frame_buffer_scheduler #(
        .BASE_ADDR   (32'h1000_0000),
        .FRAME_STRIDE(32'h0004_0000),
        .CNT_W       (16)
    ) dut (
        .p_clock(p_clock),
        .rst    (rst),
        .bus    (bus)
    );

    always #5 p_clock = ~p_clock;

    int total = 0;
    int bad   = 0;
    bit chk_on = 1'b0;

    // Behavioural model. Writer phase: 0 idle, 1 armed, 2 writing.
    int m_phase, m_w, m_p, m_r, m_written, m_dropped;
    bit m_pend, m_rdv;
    bit p_s, p_e, p_rd;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] addr(input int idx);
        return 32'h1000_0000 + 32'(idx) * 32'h0004_0000;
    endfunction

    task automatic model_cycle(input bit en, input bit s, input bit e, input bit rd, input bit r);
        bit es, ee, er;
        int t;
        if (r) begin
            m_phase = 0; m_w = 0; m_p = 1; m_r = 2;
            m_pend = 0; m_rdv = 0; m_written = 0; m_dropped = 0;
            p_s = 0; p_e = 0; p_rd = 0;
            return;
        end
        es = s && !p_s; ee = e && !p_e; er = rd && !p_rd;
        p_s = s; p_e = e; p_rd = rd;
        if (m_phase == 0) begin
            if (en) m_phase = 1;
        end else if (m_phase == 1) begin
            if (!en) m_phase = 0;
            else if (es) m_phase = 2;
        end else begin
            if (ee) begin
                t = m_w; m_w = m_p; m_p = t;
                if (m_pend && m_dropped < 65535) m_dropped++;
                m_pend = 1;
                m_written = (m_written + 1) % 65536;
                m_phase = es ? 2 : (en ? 1 : 0);
            end else if (es) begin
                if (m_dropped < 65535) m_dropped++;
            end
        end
        if (er && m_pend) begin
            t = m_r; m_r = m_p; m_p = t;
            m_pend = 0; m_rdv = 1;
        end
    endtask

    // Drive one cycle of input levels and advance the model at the edge.
    task automatic step(input bit en, input bit s, input bit e, input bit rd, input bit r);
        @(negedge p_clock);
        #1;
        bus.enable = en; bus.wr_frame_start = s; bus.wr_frame_end = e;
        bus.rd_frame_start = rd; rst = r;
        @(posedge p_clock);
        model_cycle(en, s, e, rd, r);
        chk_on = 1'b1;
        #1;
    endtask

    // Per-cycle comparison against the model.
    always @(negedge p_clock) begin
        if (chk_on) begin
            chk("wr_buf_idx", 32'(bus.wr_buf_idx), 32'(m_w));
            chk("wr_base_addr", bus.wr_base_addr, addr(m_w));
            chk("wr_active", 32'(bus.wr_active), 32'(m_phase == 2));
            chk("rd_buf_idx", 32'(bus.rd_buf_idx), 32'(m_r));
            chk("rd_base_addr", bus.rd_base_addr, addr(m_r));
            chk("rd_valid", 32'(bus.rd_valid), 32'(m_rdv));
            chk("frames_written", 32'(bus.frames_written), 32'(m_written));
            chk("frames_dropped", 32'(bus.frames_dropped), 32'(m_dropped));
        end
    end

    initial begin
        bus.enable = 1'b0; bus.wr_frame_start = 1'b0;
        bus.wr_frame_end = 1'b0; bus.rd_frame_start = 1'b0;

        // Reset values.
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        chk("lit_rst_wr_addr", bus.wr_base_addr, 32'h1000_0000);
        chk("lit_rst_rd_addr", bus.rd_base_addr, 32'h1008_0000);
        chk("lit_rst_rd_valid", 32'(bus.rd_valid), 32'd0);

        // Enable, then a 3-cycle start pulse gives one event.
        step(1, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        chk("lit_start_active", 32'(bus.wr_active), 32'd1);
        chk("lit_start_addr", bus.wr_base_addr, 32'h1000_0000);
        chk("lit_start_dropped", 32'(bus.frames_dropped), 32'd0);

        // End, then read.
        step(1, 0, 1, 0, 0);
        chk("lit_end_w", 32'(bus.wr_buf_idx), 32'd1);
        chk("lit_end_written", 32'(bus.frames_written), 32'd1);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 1, 0);
        chk("lit_rd_r", 32'(bus.rd_buf_idx), 32'd0);
        chk("lit_rd_addr", bus.rd_base_addr, 32'h1000_0000);
        chk("lit_rd_valid", 32'(bus.rd_valid), 32'd1);
        chk("lit_rd_wr_addr", bus.wr_base_addr, 32'h1004_0000);
        step(1, 0, 0, 0, 0);

        // Two frames, no read: second end overwrites an unread frame.
        step(1, 1, 0, 0, 0); step(1, 0, 0, 0, 0);
        step(1, 0, 1, 0, 0); step(1, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0); step(1, 0, 0, 0, 0);
        step(1, 0, 1, 0, 0); step(1, 0, 0, 0, 0);
        chk("lit_two_dropped", 32'(bus.frames_dropped), 32'd1);
        chk("lit_two_written", 32'(bus.frames_written), 32'd3);
        step(1, 0, 0, 1, 0); step(1, 0, 0, 0, 0);
        chk("lit_newest_r", 32'(bus.rd_buf_idx), 32'd2);

        // Aborted frame: start, start, end.
        step(1, 1, 0, 0, 0); step(1, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        chk("lit_abort_noswap", 32'(bus.wr_buf_idx), 32'd1);
        chk("lit_abort_dropped", 32'(bus.frames_dropped), 32'd2);
        step(1, 0, 0, 0, 0);
        step(1, 0, 1, 0, 0); step(1, 0, 0, 0, 0);
        chk("lit_abort_written", 32'(bus.frames_written), 32'd4);

        // End and read together while a frame is pending.
        step(1, 1, 0, 0, 0); step(1, 0, 0, 0, 0);
        step(1, 0, 1, 1, 0);
        chk("lit_both_r", 32'(bus.rd_buf_idx), 32'd0);
        chk("lit_both_w", 32'(bus.wr_buf_idx), 32'd1);
        chk("lit_both_dropped", 32'(bus.frames_dropped), 32'd3);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 1, 0);
        chk("lit_repeat_r", 32'(bus.rd_buf_idx), 32'd0);
        step(1, 0, 0, 0, 0);

        // Enable drops mid-frame: the frame still completes, then idle.
        step(1, 1, 0, 0, 0); step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("lit_dis_active", 32'(bus.wr_active), 32'd1);
        step(0, 0, 1, 0, 0);
        chk("lit_dis_done", 32'(bus.wr_active), 32'd0);
        chk("lit_dis_w", 32'(bus.wr_buf_idx), 32'd2);
        step(0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0); step(0, 0, 0, 0, 0);
        chk("lit_dis_ignored", 32'(bus.wr_active), 32'd0);

        // Reset mid-frame.
        step(1, 0, 0, 0, 0); step(1, 1, 0, 0, 0); step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 1);
        chk("lit_mid_rst_w", 32'(bus.wr_buf_idx), 32'd0);
        chk("lit_mid_rst_cnt", 32'(bus.frames_written), 32'd0);

        // Randomized event levels.
        for (int i = 0; i < 4000; i++) begin
            step($urandom_range(0, 9) != 0,
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 4) == 0,
                 $urandom_range(0, 499) == 0);
        end

        @(negedge p_clock);
        #1;
        chk_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
